mux_nto1_pipe: RTL
==================

Name: mux_nto1_pipe

Overview:
Parametrised successor to the generic combinational muxes: an N-to-1 word selector with a registered output and a valid/ready handshake. It includes a 2-entry skid buffer, so upstream and downstream stalls never drop or duplicate a word. It is intended for OTTER pipeline stage boundaries (e.g. writeback-source select, forwarding select) where the selected value must be registered and stall-safe.

Parameters:
WIDTH, 32, data word width in bits (>=1)
NUM_IN, 2, number of data inputs (>=2)
SEL_W, $clog2(NUM_IN), select width; derived, do not override

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of all buffered words
in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
in_sel  input  SEL_W  input index to capture
in_valid  input  1  upstream word/select valid
in_ready  output  1  block can accept this cycle
out_data  output  WIDTH  selected, registered word
out_sel  output  SEL_W  in_sel value captured with out_data
out_valid  output  1  out_data/out_sel valid
out_ready  input  1  downstream accepts this cycle

Behaviour:
- Reset: RST is synchronous, active-high on CLK. While RST=1 at a rising edge, all state clears. After reset: out_valid=0, out_data=0, out_sel=0, in_ready=1, skid empty.
- Selection: the captured word is in_data[in_sel*WIDTH +: WIDTH].
- Out-of-range in_sel (>= NUM_IN, possible when NUM_IN is not a power of 2) selects input NUM_IN-1. This generalises "default selects last input".
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Storage: main register M drives the outputs. Skid register S holds one overflow word.
- in_ready = !S.valid. It is registered and does not depend combinationally on out_ready.
- Latency: 1 cycle from input transfer to out_valid when M is empty or draining. Full throughput is 1 word/cycle with out_ready held high.
- States, encoded by (M.valid, S.valid):
  - EMPTY (0,0):
    - input transfer -> ONE, M loads.
  - ONE (1,0):
    - input and output transfer together -> ONE, M reloads.
    - input transfer only -> FULL, S loads.
    - output transfer only -> EMPTY.
  - FULL (1,1), in_ready=0:
    - output transfer -> ONE, M<=S.
- Ordering: strictly FIFO. Words exit in acceptance order, never dropped, never duplicated.
- Data/select stability: out_data and out_sel are held stable while out_valid && !out_ready.
- flush: at the edge, clears M.valid and S.valid, and any same-cycle input transfer is discarded. Data registers keep their old contents. in_ready=1 the following cycle. RST takes priority over flush.
- Reset mid-operation: any buffered words are discarded; no output transfer occurs after the reset edge.
- in_valid is sampled only at edges; there are no combinational paths in->out.

Optional Feature:
Macro MUX_SEL_RANGE_CHECK_EN.
- Defined: adds output port sel_err (1 bit, reset 0). sel_err is registered alongside out_data and is set when the captured in_sel >= NUM_IN. It travels through S with its word and is valid only while out_valid=1. Selection still falls back to input NUM_IN-1.
- Not defined: no sel_err port, no range-check logic. When NUM_IN is a power of 2 the check is constant 0 either way.

Test Plan:
- Reset/basic (WIDTH=32, NUM_IN=4): after reset, check out_valid=0, in_ready=1. Send in_data={D,C,B,A}=0x44..,0x33..,0x22..,0x11.., sel=2 with out_ready=1 -> next cycle out_valid=1, out_data=0x33333333, out_sel=2.
- Back-to-back throughput: 8 words, sel cycling 0..3, in_valid and out_ready held 1 -> 8 consecutive output beats, in order, no bubbles after first-cycle latency.
- Stall/skid: out_ready=0, feed words W0,W1 -> in_ready falls to 0 after W1, out_data=W0 stable. Raise out_ready -> W0 then W1 appear, in_ready returns 1.
- Out-of-range (NUM_IN=3, SEL_W=2): sel=3 -> out_data=in_data[2], out_sel=3. With MUX_SEL_RANGE_CHECK_EN, sel_err=1; sel=1 -> sel_err=0.
- flush while FULL: flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed words never appear at output.
- Reset mid-stream: assert RST with FULL and out_ready=0 -> next cycle out_valid=0, out_data=0, in_ready=1.

Source files
------------

// File: rtl/mux_nto1_pipe.sv
// N-to-1 word selector with registered output, valid/ready handshake and a 2-entry skid buffer.
// Optional macro MUX_SEL_RANGE_CHECK_EN adds a sel_err output flagging out-of-range selects.
module mux_nto1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_SEL_RANGE_CHECK_EN
  ,
  output logic                    sel_err
`endif
);

  // Encoding mirrors (M.valid, S.valid).
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [SEL_W-1:0] m_sel_q, m_sel_d, s_sel_q, s_sel_d;
  logic [WIDTH-1:0] sel_word;
  logic             in_xfer, out_xfer;
  logic             m_load_in, m_load_s, s_load;

  // Any select not matching a lower index (including out-of-range) falls to the last input.
  always_comb begin
    sel_word = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int unsigned k = 0; k < NUM_IN - 1; k++) begin
      if (in_sel == SEL_W'(k)) sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    m_load_in = 1'b0;
    m_load_s  = 1'b0;
    s_load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = ONE;
          m_load_in = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          m_load_in = 1'b1;
        end else if (in_xfer) begin
          state_d = FULL;
          s_load  = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d  = ONE;
          m_load_s = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush empties both slots and discards the same-cycle input; data contents are left as-is.
    if (flush) begin
      state_d   = EMPTY;
      m_load_in = 1'b0;
      m_load_s  = 1'b0;
      s_load    = 1'b0;
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
  end

  always_comb begin
    m_data_d = m_data_q;
    m_sel_d  = m_sel_q;
    s_data_d = s_data_q;
    s_sel_d  = s_sel_q;
    if (m_load_in) begin
      m_data_d = sel_word;
      m_sel_d  = in_sel;
    end else if (m_load_s) begin
      m_data_d = s_data_q;
      m_sel_d  = s_sel_q;
    end
    if (s_load) begin
      s_data_d = sel_word;
      s_sel_d  = in_sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_data_q <= '0;
      m_sel_q  <= '0;
      s_data_q <= '0;
      s_sel_q  <= '0;
    end else begin
      m_data_q <= m_data_d;
      m_sel_q  <= m_sel_d;
      s_data_q <= s_data_d;
      s_sel_q  <= s_sel_d;
    end
  end

  assign out_data = m_data_q;
  assign out_sel  = m_sel_q;

`ifdef MUX_SEL_RANGE_CHECK_EN
  logic sel_oor;
  logic m_err_q, m_err_d, s_err_q, s_err_d;

  assign sel_oor = (32'(in_sel) >= 32'(NUM_IN));

  always_comb begin
    m_err_d = m_err_q;
    s_err_d = s_err_q;
    if (m_load_in)     m_err_d = sel_oor;
    else if (m_load_s) m_err_d = s_err_q;
    if (s_load)        s_err_d = sel_oor;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_err_q <= 1'b0;
      s_err_q <= 1'b0;
    end else begin
      m_err_q <= m_err_d;
      s_err_q <= s_err_d;
    end
  end

  assign sel_err = m_err_q;
`endif

endmodule
